// File: rtl/fpa_core.sv
// fpa_core: IEEE 754 binary16 adder, round-to-nearest-even, one-cycle registered result.
// Optional feature macro FPA_DENORM_EN: defined -> gradual underflow;
// undefined -> flush-to-zero on subnormal inputs and results.
module fpa_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out,
    output logic        out_valid
);

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 11;
    localparam int unsigned EXT_W = MAN_W + 3;
    localparam int unsigned EW    = 7;

    localparam logic [15:0] QNAN = 16'h7E00;

    // Leading-zero count of the extended significand (14 when all zero).
    function automatic logic [3:0] lzc14(input logic [EXT_W-1:0] v);
        lzc14 = 4'd14;
        for (int i = 0; i < int'(EXT_W); i++) begin
            if (v[i]) lzc14 = 4'(13 - i);
        end
    endfunction

    logic [15:0]        a_f, b_f;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]        big, sml;
    logic [EXP_W-1:0]   e_l, e_s, d;
    logic [MAN_W-1:0]   m_l, m_s;
    logic [EXT_W-1:0]   l_ext, s_ext, diff, norm;
    logic [2*EXT_W-1:0] sh_full;
    logic [EXT_W:0]     sum15;
    logic               eff_sub;
    logic [3:0]         lz;
    logic [EW-1:0]      sh, exp_n, exp_r;
    logic [MAN_W-1:0]   m_n;
    logic               rnd;
    logic [MAN_W:0]     m_r;
    logic               hid;
    logic [9:0]         frac_o;
    logic [15:0]        norm_res;
    logic [15:0]        sum_c;

    // Subnormal operands become signed zero in flush-to-zero builds.
    always_comb begin
`ifdef FPA_DENORM_EN
        a_f = a;
        b_f = b;
`else
        a_f = (a[14:10] == 5'd0) ? {a[15], 15'd0} : a;
        b_f = (b[14:10] == 5'd0) ? {b[15], 15'd0} : b;
`endif
    end

    // Classify, align, add/subtract, normalise and round.
    always_comb begin
        a_nan   = (&a[14:10]) & (|a[9:0]);
        b_nan   = (&b[14:10]) & (|b[9:0]);
        a_inf   = (&a[14:10]) & ~(|a[9:0]);
        b_inf   = (&b[14:10]) & ~(|b[9:0]);
        a_zero  = ~(|a_f[14:0]);
        b_zero  = ~(|b_f[14:0]);

        big     = (a_f[14:0] >= b_f[14:0]) ? a_f : b_f;
        sml     = (a_f[14:0] >= b_f[14:0]) ? b_f : a_f;
        eff_sub = big[15] ^ sml[15];

        e_l     = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
        e_s     = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
        m_l     = {|big[14:10], big[9:0]};
        m_s     = {|sml[14:10], sml[9:0]};
        d       = e_l - e_s;

        l_ext   = {m_l, 3'b000};
        sh_full = {m_s, 3'b000, 14'd0} >> d;
        if (d >= 5'd14) begin
            s_ext = {13'd0, |m_s};
        end else begin
            s_ext = sh_full[2*EXT_W-1:EXT_W] | {13'd0, |sh_full[EXT_W-1:0]};
        end

        sum15 = {1'b0, l_ext} + {1'b0, s_ext};
        diff  = l_ext - s_ext;
        lz    = lzc14(diff);
        sh    = 7'd0;
        norm  = sum15[EXT_W-1:0];
        exp_n = EW'(e_l);

        if (!eff_sub) begin
            // Carry-out: shift right one, folding the lost bit into sticky.
            if (sum15[EXT_W]) begin
                norm  = sum15[EXT_W:1] | {13'd0, sum15[0]};
                exp_n = EW'(e_l) + 7'd1;
            end
        end else begin
            // Normalise left, but never below the minimum exponent.
            sh    = (EW'(lz) < (EW'(e_l) - 7'd1)) ? EW'(lz) : (EW'(e_l) - 7'd1);
            norm  = diff << sh;
            exp_n = EW'(e_l) - sh;
        end

        m_n = norm[EXT_W-1:3];
        rnd = norm[2] & ((|norm[1:0]) | m_n[0]);
        m_r = {1'b0, m_n} + 12'(rnd);

        if (m_r[MAN_W]) begin
            frac_o = 10'd0;
            hid    = 1'b1;
            exp_r  = exp_n + 7'd1;
        end else begin
            frac_o = m_r[9:0];
            hid    = m_r[MAN_W-1];
            exp_r  = exp_n;
        end

        if (hid && (exp_r >= 7'd31)) begin
            norm_res = {big[15], 5'h1F, 10'd0};
        end else if (hid) begin
            norm_res = {big[15], exp_r[EXP_W-1:0], frac_o};
        end else begin
`ifdef FPA_DENORM_EN
            norm_res = {big[15], 5'd0, frac_o};
`else
            norm_res = {big[15], 15'd0};
`endif
        end

        if (a_nan || b_nan) begin
            sum_c = QNAN;
        end else if (a_inf && b_inf && (a[15] != b[15])) begin
            sum_c = QNAN;
        end else if (a_inf) begin
            sum_c = a;
        end else if (b_inf) begin
            sum_c = b;
        end else if (a_zero && b_zero) begin
            sum_c = {a_f[15] & b_f[15], 15'd0};
        end else if (a_zero) begin
            sum_c = b_f;
        end else if (b_zero) begin
            sum_c = a_f;
        end else if (eff_sub && (diff == 14'd0)) begin
            sum_c = 16'h0000;
        end else begin
            sum_c = norm_res;
        end
    end

    logic [15:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;

    // Capture a new sum only on accepted operations.
    always_comb begin
        out_d       = out_q;
        out_valid_d = in_valid;
        if (in_valid) out_d = sum_c;
    end

    // Output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fpa_core.sv
// Testbench for fpa_core: directed vectors plus a real-arithmetic reference model.
module tb_fpa_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [31:0] op_q[$];

`ifdef FPA_DENORM_EN
    localparam bit DENORM = 1'b1;
`else
    localparam bit DENORM = 1'b0;
`endif

    fpa_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact sum in double precision, then RNE to binary16.
    function automatic real pow2(input int e);
        real p = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
        else        for (int i = 0; i < -e; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real m;
        int  e = int'(h[14:10]);
        if (e == 0) m = real'(int'(h[9:0])) * pow2(-24);
        else        m = real'(1024 + int'(h[9:0])) * pow2(e - 25);
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        logic s = (x < 0.0);
        real  ax = s ? -x : x;
        int   e = 15;
        real  q, fr;
        int   n, bits;
        while (e > -14 && ax < pow2(e)) e--;
        q  = ax / pow2(e - 10);
        n  = int'($floor(q));
        fr = q - real'(n);
        if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
        bits = (e + 15) * 1024 + n - 1024;
        if (bits >= 31744) bits = 31744;
        return {s, 15'(bits)};
    endfunction

    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] xf = x, yf = y, r;
        logic xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
        logic yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
        logic xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
        logic yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
        real  s;
        if (!DENORM && x[14:10] == 0) xf = {x[15], 15'd0};
        if (!DENORM && y[14:10] == 0) yf = {y[15], 15'd0};
        if (xn || yn) return 16'h7E00;
        if (xi && yi) return (x[15] != y[15]) ? 16'h7E00 : x;
        if (xi) return x;
        if (yi) return y;
        if (xf[14:0] == 0 && yf[14:0] == 0) return {xf[15] & yf[15], 15'd0};
        s = h2r(xf) + h2r(yf);
        if (s == 0.0) return 16'h0000;
        r = r2h(s);
        if (!DENORM && r[14:10] == 0 && r[9:0] != 0) r = {r[15], 15'd0};
        return r;
    endfunction

    // Scoreboard: compare every valid output against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid out=%h", out);
            end else begin
                logic [15:0] e;
                logic [31:0] o;
                e = exp_q.pop_front();
                o = op_q.pop_front();
                if (out !== e) begin
                    bad++;
                    $display("FAIL sum a=%h b=%h got=%h want=%h", o[31:16], o[15:0], out, e);
                end
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] e);
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        exp_q.push_back(e);
        op_q.push_back({x, y});
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
            exp_q.delete();
            op_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 16'h4300;
        b = 16'h4480;
        repeat (3) @(negedge clk);
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h want=0000", out); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", out_valid); end
        send(16'h4300, 16'h4480, 16'h4800);
        drain();
    endtask

    task automatic test_basic();
        send(16'h4300, 16'h4480, 16'h4800);
        send(16'h3C00, 16'h3C00, 16'h4000);
        send(16'h4000, 16'hBC00, 16'h3C00);
        send(16'hC000, 16'h3800, 16'hBE00);
        drain();
    endtask

    task automatic test_cancel_zero();
        send(16'h3C00, 16'hBC00, 16'h0000);
        send(16'hBC00, 16'h3C00, 16'h0000);
        send(16'h0000, 16'hC480, 16'hC480);
        send(16'h8000, 16'h8000, 16'h8000);
        send(16'h8000, 16'h0000, 16'h0000);
        send(16'h3555, 16'h8000, 16'h3555);
        drain();
    endtask

    task automatic test_rounding();
        send(16'h3C00, 16'h1000, 16'h3C00);
        send(16'h3C01, 16'h1000, 16'h3C02);
        send(16'h3C00, 16'h1001, 16'h3C01);
        send(16'h3C00, 16'h0C00, 16'h3C00);
        drain();
    endtask

    task automatic test_specials();
        send(16'h7BFF, 16'h7BFF, 16'h7C00);
        send(16'hFBFF, 16'hFBFF, 16'hFC00);
        send(16'h7C00, 16'hFC00, 16'h7E00);
        send(16'h7C01, 16'h3C00, 16'h7E00);
        send(16'h3C00, 16'hFE00, 16'h7E00);
        send(16'h7C00, 16'h7C00, 16'h7C00);
        send(16'hFC00, 16'h4000, 16'hFC00);
        drain();
    endtask

    task automatic test_subnormal();
        send(16'h0001, 16'h0001, DENORM ? 16'h0002 : 16'h0000);
        send(16'h0400, 16'h8001, DENORM ? 16'h03FF : 16'h0400);
        send(16'h0401, 16'h8400, DENORM ? 16'h0001 : 16'h0000);
        send(16'h03FF, 16'h0001, DENORM ? 16'h0400 : 16'h0000);
        send(16'h8401, 16'h0400, DENORM ? 16'h8001 : 16'h8000);
        drain();
    endtask

    task automatic test_hold();
        send(16'h3C00, 16'h3C00, 16'h4000);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'h7BFF;
        b = 16'h7BFF;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out !== 16'h4000 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL hold got=%h/%b want=4000/0", out, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h4300;
        b = 16'h4480;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out !== 16'h0000 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got=%h/%b want=0000/0", out, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h3C01, 16'h1000, 16'h3C02);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] x, y;
            int e;
            x = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0: y = 16'($urandom_range(0, 65535));
                1: y = x ^ 16'h8000;
                2: y = (x ^ 16'h8000) + 16'($urandom_range(0, 2));
                default: begin
                    e = int'(x[14:10]) + int'($urandom_range(0, 6)) - 3;
                    if (e < 0) e = 0;
                    if (e > 30) e = 30;
                    y = {1'($urandom_range(0, 1)), 5'(e), 10'($urandom_range(0, 1023))};
                end
            endcase
            send(x, y, model(x, y));
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        test_reset();
        test_basic();
        test_cancel_zero();
        test_rounding();
        test_specials();
        test_subnormal();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
